// File: rtl/mem_port_sequencer_if.sv
// Bundle of fetch/data requester handshakes and the shared memory port.
// master = requester/memory side, slave = sequencer side.
interface mem_port_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_done;
  logic [DATA_W-1:0] fetch_data;
  logic              data_req;
  logic              data_wr;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_done;
  logic [DATA_W-1:0] data_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_data_in;
  logic              busy;
  logic              grant_data;

  modport master (
    output fetch_req, fetch_addr, data_req, data_wr, data_addr, data_wdata, mem_data_in,
    input  fetch_done, fetch_data, data_done, data_rdata, mem_addr, mem_wr, mem_wdata,
    input  busy, grant_data
  );

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_wr, data_addr, data_wdata, mem_data_in,
    output fetch_done, fetch_data, data_done, data_rdata, mem_addr, mem_wr, mem_wdata,
    output busy, grant_data
  );
endinterface

// File: rtl/mem_port_sequencer.sv
// Shares one memory port between instruction fetch and load/store with fixed read latency.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data always wins ties.
module mem_port_sequencer #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 2
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRead, StCapture, StWrite, StDone} state_e;

  localparam logic [3:0] CntInit = 4'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              grant_data_q;
  logic              any_req;
  logic              pick_data;

  assign any_req = bus.fetch_req | bus.data_req;

`ifdef MEM_ARB_RR_EN
  logic rr_data_q;

  // Pointer only matters on ties; a lone requester is always granted.
  assign pick_data = bus.data_req & (~bus.fetch_req | rr_data_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_data_q <= 1'b1;
    end else if (state_q == StDone) begin
      rr_data_q <= ~grant_data_q;
    end
  end
`else
  assign pick_data = bus.data_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = (pick_data && bus.data_wr) ? StWrite : StRead;
          cnt_d   = CntInit;
        end
      end
      StRead: begin
        if (cnt_q == 4'd0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCapture: state_d = StDone;
      StWrite:   state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
      grant_data_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && any_req) begin
        grant_data_q <= pick_data;
        addr_q       <= pick_data ? bus.data_addr : bus.fetch_addr;
        if (pick_data) begin
          wdata_q <= bus.data_wdata;
        end
      end
      if (state_q == StCapture) begin
        if (grant_data_q) begin
          data_rdata_q <= bus.mem_data_in;
        end else begin
          fetch_data_q <= bus.mem_data_in;
        end
      end
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wr     = (state_q == StWrite);
  assign bus.fetch_done = (state_q == StDone) & ~grant_data_q;
  assign bus.data_done  = (state_q == StDone) & grant_data_q;
  assign bus.fetch_data = fetch_data_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.grant_data = grant_data_q;

endmodule
